// File: rtl/kdtree_pkg.sv
// Shared constants, FSM state type and record layouts for the k-d tree stream loader.
package kdtree_pkg;
   localparam int DATA_WIDTH  = 11;
   localparam int IDX_WIDTH   = 9;
   localparam int PATCH_SIZE  = 5;
   localparam int LEAF_SIZE   = 8;
   localparam int NUM_LEAVES  = 64;
   localparam int NUM_QUERYS  = 494;
   localparam int LEAF_ADDRW  = $clog2(NUM_LEAVES);
   localparam int QUERY_ADDRW = $clog2(NUM_QUERYS);
   localparam int SLOT_W      = $clog2(LEAF_SIZE);

   localparam int NUM_NODES            = NUM_LEAVES - 1;
   localparam int NUM_LEAF_PATCHES     = NUM_LEAVES * LEAF_SIZE;
   localparam int WORDS_PER_NODE       = 2;
   localparam int WORDS_PER_LEAF_PATCH = PATCH_SIZE + 1;
   localparam int WORDS_PER_QUERY      = PATCH_SIZE;
   localparam int NODE_WORDS           = NUM_NODES * WORDS_PER_NODE;
   localparam int LEAF_WORDS           = NUM_LEAF_PATCHES * WORDS_PER_LEAF_PATCH;
   localparam int QUERY_WORDS          = NUM_QUERYS * WORDS_PER_QUERY;
   localparam int TOTAL_WORDS          = NODE_WORDS + LEAF_WORDS + QUERY_WORDS;

   localparam int MAX_REC_WORDS = WORDS_PER_LEAF_PATCH;
   localparam int REC_LEN_W     = $clog2(MAX_REC_WORDS + 1);
   // One record counter serves every section, so it must cover the largest one.
   localparam int REC_CNT_W     = (LEAF_ADDRW + SLOT_W > QUERY_ADDRW) ? (LEAF_ADDRW + SLOT_W) : QUERY_ADDRW;
   localparam int LEAF_WDATA_W  = PATCH_SIZE * DATA_WIDTH + IDX_WIDTH;
   localparam int QUERY_WDATA_W = PATCH_SIZE * DATA_WIDTH;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      NODES   = 3'd1,
      LEAVES  = 3'd2,
      QUERIES = 3'd3,
      DONE    = 3'd4
   } state_t;

   typedef struct packed {
      logic [IDX_WIDTH-1:0]                   idx;
      logic [PATCH_SIZE-1:0][DATA_WIDTH-1:0]  data;
   } leaf_patch_t;
endpackage

// File: rtl/word_gatherer.sv
// Collects stream words into one record of runtime-selected length and flags the
// pop that completes it; the returned record already includes that final word.
module word_gatherer #(
   parameter int N     = 6,
   parameter int W     = 11,
   parameter int LEN_W = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             shift_en,
   input  logic [W-1:0]     din,
   input  logic [LEN_W-1:0] len,
   output logic [N*W-1:0]   rec,
   output logic             rec_done
);
   localparam int CNT_W = $clog2(N);

   logic [CNT_W-1:0]       cnt_r;
   logic [N-1:0][W-1:0]    words_r;
   logic                   last_s;

   // Final word of the record is being popped this cycle.
   always_comb begin
      last_s   = shift_en & ((LEN_W'(cnt_r) + LEN_W'(1)) == len);
      rec_done = last_s;
   end

   // Present stored words with the in-flight word merged at its slot.
   always_comb begin
      rec = words_r;
      for (int k = 0; k < N; k++) begin
         if (shift_en && (cnt_r == CNT_W'(k))) begin
            rec[k*W +: W] = din;
         end else begin
            rec[k*W +: W] = words_r[k];
         end
      end
   end

   // Word slot counter and storage.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_r   <= '0;
         words_r <= '0;
      end else if (clr) begin
         cnt_r   <= '0;
         words_r <= '0;
      end else if (shift_en) begin
         words_r[cnt_r] <= din;
         cnt_r          <= last_s ? CNT_W'(0) : cnt_r + CNT_W'(1);
      end
   end
endmodule

// File: rtl/kdtree_stream_loader.sv
// Deserialises the host word stream into node, leaf and query memory writes.
// Define KDTREE_LOADER_CHECK_EN to add the sticky load_err range checker.
module kdtree_stream_loader
   import kdtree_pkg::*;
(
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     load_kdtree,
   input  logic                     fifo_rempty_n,
   input  logic [DATA_WIDTH-1:0]    fifo_rdata,
   output logic                     fifo_deq,
   output logic                     node_wen,
   output logic [LEAF_ADDRW-1:0]    node_waddr,
   output logic [2:0]               node_dim,
   output logic [DATA_WIDTH-1:0]    node_median,
   output logic                     leaf_wen,
   output logic [LEAF_ADDRW-1:0]    leaf_waddr,
   output logic [SLOT_W-1:0]        leaf_slot,
   output logic [LEAF_WDATA_W-1:0]  leaf_wdata,
   output logic                     query_wen,
   output logic [QUERY_ADDRW-1:0]   query_waddr,
   output logic [QUERY_WDATA_W-1:0] query_wdata,
   output logic                     load_busy,
   output logic                     load_done
`ifdef KDTREE_LOADER_CHECK_EN
   ,
   output logic                     load_err
`endif
);
   state_t                                 state_r;
   logic [REC_CNT_W-1:0]                   rec_cnt_r;
   logic                                   pop_s;
   logic                                   accept_s;
   logic                                   last_rec_s;
   logic [REC_LEN_W-1:0]                   len_s;
   logic [MAX_REC_WORDS*DATA_WIDTH-1:0]    rec_s;
   logic                                   rec_done_s;
   logic [MAX_REC_WORDS-1:0][DATA_WIDTH-1:0] word_s;
   leaf_patch_t                            patch_s;

   logic                     node_wen_r;
   logic [LEAF_ADDRW-1:0]    node_waddr_r;
   logic [2:0]               node_dim_r;
   logic [DATA_WIDTH-1:0]    node_median_r;
   logic                     leaf_wen_r;
   logic [LEAF_ADDRW-1:0]    leaf_waddr_r;
   logic [SLOT_W-1:0]        leaf_slot_r;
   leaf_patch_t              leaf_wdata_r;
   logic                     query_wen_r;
   logic [QUERY_ADDRW-1:0]   query_waddr_r;
   logic [QUERY_WDATA_W-1:0] query_wdata_r;
   logic                     load_busy_r;
   logic                     load_done_r;

   // Pop enable, record length and end-of-section detection per state.
   always_comb begin
      pop_s      = 1'b0;
      len_s      = REC_LEN_W'(MAX_REC_WORDS);
      last_rec_s = 1'b0;
      accept_s   = 1'b0;
      case (state_r)
         NODES: begin
            pop_s      = fifo_rempty_n;
            len_s      = REC_LEN_W'(WORDS_PER_NODE);
            last_rec_s = (rec_cnt_r == REC_CNT_W'(NUM_NODES - 1));
         end
         LEAVES: begin
            pop_s      = fifo_rempty_n;
            len_s      = REC_LEN_W'(WORDS_PER_LEAF_PATCH);
            last_rec_s = (rec_cnt_r == REC_CNT_W'(NUM_LEAF_PATCHES - 1));
         end
         QUERIES: begin
            pop_s      = fifo_rempty_n;
            len_s      = REC_LEN_W'(WORDS_PER_QUERY);
            last_rec_s = (rec_cnt_r == REC_CNT_W'(NUM_QUERYS - 1));
         end
         IDLE, DONE: begin
            accept_s = load_kdtree;
         end
         default: begin
            pop_s = 1'b0;
         end
      endcase
   end

   assign fifo_deq = pop_s;

   word_gatherer #(
      .N     (MAX_REC_WORDS),
      .W     (DATA_WIDTH),
      .LEN_W (REC_LEN_W)
   ) u_gatherer (
      .clk      (clk),
      .rst      (rst),
      .clr      (accept_s),
      .shift_en (pop_s),
      .din      (fifo_rdata),
      .len      (len_s),
      .rec      (rec_s),
      .rec_done (rec_done_s)
   );

   assign word_s = rec_s;

   // Leaf record layout: index word follows the data words.
   always_comb begin
      patch_s.idx = word_s[PATCH_SIZE][IDX_WIDTH-1:0];
      for (int k = 0; k < PATCH_SIZE; k++) begin
         patch_s.data[k] = word_s[k];
      end
   end

   // Load sequencer with registered write strobes, addresses and data.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r       <= IDLE;
         rec_cnt_r     <= '0;
         node_wen_r    <= 1'b0;
         node_waddr_r  <= '0;
         node_dim_r    <= 3'd0;
         node_median_r <= '0;
         leaf_wen_r    <= 1'b0;
         leaf_waddr_r  <= '0;
         leaf_slot_r   <= '0;
         leaf_wdata_r  <= '0;
         query_wen_r   <= 1'b0;
         query_waddr_r <= '0;
         query_wdata_r <= '0;
         load_busy_r   <= 1'b0;
         load_done_r   <= 1'b0;
      end else begin
         node_wen_r  <= 1'b0;
         leaf_wen_r  <= 1'b0;
         query_wen_r <= 1'b0;
         case (state_r)
            IDLE, DONE: begin
               if (load_kdtree) begin
                  state_r     <= NODES;
                  rec_cnt_r   <= '0;
                  load_busy_r <= 1'b1;
                  load_done_r <= 1'b0;
               end
            end
            NODES: begin
               if (rec_done_s) begin
                  node_wen_r    <= 1'b1;
                  node_waddr_r  <= rec_cnt_r[LEAF_ADDRW-1:0];
                  node_dim_r    <= word_s[0][2:0];
                  node_median_r <= word_s[1];
                  rec_cnt_r     <= last_rec_s ? REC_CNT_W'(0) : rec_cnt_r + REC_CNT_W'(1);
                  if (last_rec_s) state_r <= LEAVES;
               end
            end
            LEAVES: begin
               if (rec_done_s) begin
                  leaf_wen_r   <= 1'b1;
                  leaf_waddr_r <= rec_cnt_r[SLOT_W +: LEAF_ADDRW];
                  leaf_slot_r  <= rec_cnt_r[SLOT_W-1:0];
                  leaf_wdata_r <= patch_s;
                  rec_cnt_r    <= last_rec_s ? REC_CNT_W'(0) : rec_cnt_r + REC_CNT_W'(1);
                  if (last_rec_s) state_r <= QUERIES;
               end
            end
            QUERIES: begin
               if (rec_done_s) begin
                  query_wen_r   <= 1'b1;
                  query_waddr_r <= rec_cnt_r[QUERY_ADDRW-1:0];
                  query_wdata_r <= word_s[PATCH_SIZE-1:0];
                  rec_cnt_r     <= last_rec_s ? REC_CNT_W'(0) : rec_cnt_r + REC_CNT_W'(1);
                  if (last_rec_s) begin
                     state_r     <= DONE;
                     load_busy_r <= 1'b0;
                     load_done_r <= 1'b1;
                  end
               end
            end
            default: begin
               state_r <= IDLE;
            end
         endcase
      end
   end

`ifdef KDTREE_LOADER_CHECK_EN
   logic load_err_r;
   logic err_hit_s;

   // Range violations, evaluated on the pop that completes a record.
   always_comb begin
      err_hit_s = 1'b0;
      case (state_r)
         NODES: begin
            err_hit_s = rec_done_s & (word_s[0] >= DATA_WIDTH'(PATCH_SIZE));
         end
         LEAVES: begin
            err_hit_s = rec_done_s & ((word_s[PATCH_SIZE] >= DATA_WIDTH'(NUM_QUERYS)) |
                                      (|word_s[PATCH_SIZE][DATA_WIDTH-1:IDX_WIDTH]));
         end
         default: begin
            err_hit_s = 1'b0;
         end
      endcase
   end

   // Sticky error flag, cleared when a new load is accepted.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         load_err_r <= 1'b0;
      end else if (accept_s) begin
         load_err_r <= 1'b0;
      end else if (err_hit_s) begin
         load_err_r <= 1'b1;
      end
   end

   assign load_err = load_err_r;
`else
   logic unused_idx_hi_s;
   assign unused_idx_hi_s = ^word_s[PATCH_SIZE][DATA_WIDTH-1:IDX_WIDTH];
`endif

   assign node_wen    = node_wen_r;
   assign node_waddr  = node_waddr_r;
   assign node_dim    = node_dim_r;
   assign node_median = node_median_r;
   assign leaf_wen    = leaf_wen_r;
   assign leaf_waddr  = leaf_waddr_r;
   assign leaf_slot   = leaf_slot_r;
   assign leaf_wdata  = leaf_wdata_r;
   assign query_wen   = query_wen_r;
   assign query_waddr = query_waddr_r;
   assign query_wdata = query_wdata_r;
   assign load_busy   = load_busy_r;
   assign load_done   = load_done_r;
endmodule

// File: tb/tb_kdtree_stream_loader.sv
// Directed bench for kdtree_stream_loader: drives a modelled FIFO word stream and
// checks strobe counts, timing and the memory contents captured from the write ports.
module tb_kdtree_stream_loader;
   import kdtree_pkg::*;

   localparam int NW = 126;
   localparam int LW = 3072;
   localparam int QW = 2470;
   localparam int TW = 5668;

   logic        clk = 1'b0;
   logic        rst;
   logic        load_kdtree;
   logic        fifo_rempty_n;
   logic [10:0] fifo_rdata;
   logic        fifo_deq;
   logic        node_wen;
   logic [5:0]  node_waddr;
   logic [2:0]  node_dim;
   logic [10:0] node_median;
   logic        leaf_wen;
   logic [5:0]  leaf_waddr;
   logic [2:0]  leaf_slot;
   logic [63:0] leaf_wdata;
   logic        query_wen;
   logic [8:0]  query_waddr;
   logic [54:0] query_wdata;
   logic        load_busy;
   logic        load_done;
`ifdef KDTREE_LOADER_CHECK_EN
   logic        load_err;
`endif

   kdtree_stream_loader dut (
      .clk           (clk),
      .rst           (rst),
      .load_kdtree   (load_kdtree),
      .fifo_rempty_n (fifo_rempty_n),
      .fifo_rdata    (fifo_rdata),
      .fifo_deq      (fifo_deq),
      .node_wen      (node_wen),
      .node_waddr    (node_waddr),
      .node_dim      (node_dim),
      .node_median   (node_median),
      .leaf_wen      (leaf_wen),
      .leaf_waddr    (leaf_waddr),
      .leaf_slot     (leaf_slot),
      .leaf_wdata    (leaf_wdata),
      .query_wen     (query_wen),
      .query_waddr   (query_waddr),
      .query_wdata   (query_wdata),
      .load_busy     (load_busy),
      .load_done     (load_done)
`ifdef KDTREE_LOADER_CHECK_EN
      ,
      .load_err      (load_err)
`endif
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int ptr    = 0;
   bit bad_dim = 1'b0;
   bit mon_clear = 1'b1;

   // Stream contents: node 0 = {2,1023}, leaf patch 9 = {1,2,3,4,5,300}.
   function automatic logic [10:0] word_at(input int i);
      int j, n, p, k, q;
      if (i < NW) begin
         n = i / 2;
         if (i % 2 == 0) return (n == 0) ? (bad_dim ? 11'd7 : 11'd2) : 11'(n % 5);
         return (n == 0) ? 11'd1023 : 11'((n * 37 + 11) % 2048);
      end else if (i < NW + LW) begin
         j = i - NW; p = j / 6; k = j % 6;
         if (p == 9) return (k == 5) ? 11'd300 : 11'(k + 1);
         if (k == 5) return 11'((p * 3) % 494);
         return 11'((p * 7 + k * 13 + 1) % 2048);
      end else begin
         j = i - NW - LW; q = j / 5; k = j % 5;
         return 11'((q * 11 + k * 5 + 3) % 2048);
      end
   endfunction

   int          n_node, n_leaf, n_query, n_deq_empty;
   logic [2:0]  m_dim   [64];
   logic [10:0] m_med   [64];
   logic [63:0] m_leaf  [512];
   logic [54:0] m_query [512];

   // Write-port monitor: records every strobe into shadow memories.
   always @(negedge clk) begin
      if (mon_clear) begin
         n_node <= 0; n_leaf <= 0; n_query <= 0; n_deq_empty <= 0;
         for (int a = 0; a < 64; a++) begin m_dim[a] <= 3'h7; m_med[a] <= 11'h7FF; end
         for (int a = 0; a < 512; a++) begin m_leaf[a] <= '1; m_query[a] <= '1; end
      end else begin
         if (fifo_deq === 1'b1 && fifo_rempty_n !== 1'b1) n_deq_empty <= n_deq_empty + 1;
         if (node_wen === 1'b1) begin
            n_node <= n_node + 1; m_dim[node_waddr] <= node_dim; m_med[node_waddr] <= node_median;
         end
         if (leaf_wen === 1'b1) begin
            n_leaf <= n_leaf + 1; m_leaf[{leaf_waddr, leaf_slot}] <= leaf_wdata;
         end
         if (query_wen === 1'b1) begin
            n_query <= n_query + 1; m_query[query_waddr] <= query_wdata;
         end
      end
   end

   task automatic clear_mon();
      mon_clear = 1'b1;
      @(negedge clk);
      @(posedge clk); #1;
      mon_clear = 1'b0;
   endtask

   // Present words ptr..target-1; from gap_from on the FIFO has data 1 cycle in 3.
   task automatic stream(input int target, input int gap_from, input int pulse_at);
      int cyc = 0;
      bit avail;
      bit pulsed = 1'b0;
      while (ptr < target && cyc < 20000) begin
         avail         = (ptr < gap_from) || (cyc % 3 == 0);
         fifo_rempty_n = avail;
         fifo_rdata    = avail ? word_at(ptr) : 11'h555;
         load_kdtree   = (ptr == pulse_at) && !pulsed;
         if (ptr == pulse_at) pulsed = 1'b1;
         @(negedge clk);
         if (fifo_deq === 1'b1 && avail) ptr++;
         @(posedge clk); #1;
         cyc++;
      end
      load_kdtree   = 1'b0;
      fifo_rempty_n = 1'b1;
      fifo_rdata    = 11'h2AA;
      checks++;
      if (ptr < target) begin
         errors++;
         $display("FAIL stream_progress: popped %0d words, needed %0d", ptr, target);
      end
   endtask

   task automatic start_load();
      load_kdtree   = 1'b1;
      fifo_rempty_n = 1'b0;
      @(posedge clk); #1;
      load_kdtree = 1'b0;
      checks++;
      if (load_busy !== 1'b1 || load_done !== 1'b0) begin
         errors++;
         $display("FAIL start_load busy/done: got %b/%b, want 1/0", load_busy, load_done);
      end
      ptr = 0;
   endtask

   task automatic check_contents(input string tag);
      int bad;
      logic [10:0] w;
      logic [63:0] el;
      logic [54:0] eq;
      checks++;
      if (n_node !== 63 || n_leaf !== 512 || n_query !== 494) begin
         errors++;
         $display("FAIL %s strobe_counts: got %0d/%0d/%0d, want 63/512/494", tag, n_node, n_leaf, n_query);
      end
      bad = 0;
      for (int n = 0; n < 63; n++) begin
         w = word_at(2 * n);
         if (m_dim[n] !== w[2:0]) bad++;
         w = word_at(2 * n + 1);
         if (m_med[n] !== w) bad++;
      end
      checks++;
      if (bad !== 0) begin errors++; $display("FAIL %s node_contents: got %0d bad entries, want 0", tag, bad); end
      bad = 0;
      for (int p = 0; p < 512; p++) begin
         for (int k = 0; k < 5; k++) el[k*11 +: 11] = word_at(NW + p * 6 + k);
         w = word_at(NW + p * 6 + 5);
         el[63:55] = w[8:0];
         if (m_leaf[p] !== el) bad++;
      end
      checks++;
      if (bad !== 0) begin errors++; $display("FAIL %s leaf_contents: got %0d bad entries, want 0", tag, bad); end
      bad = 0;
      for (int q = 0; q < 494; q++) begin
         for (int k = 0; k < 5; k++) eq[k*11 +: 11] = word_at(NW + LW + q * 5 + k);
         if (m_query[q] !== eq) bad++;
      end
      checks++;
      if (bad !== 0) begin errors++; $display("FAIL %s query_contents: got %0d bad entries, want 0", tag, bad); end
      checks++;
      if (m_dim[0] !== 3'd2 || m_med[0] !== 11'd1023) begin
         errors++;
         $display("FAIL %s node0: got dim=%0d med=%0d, want 2/1023", tag, m_dim[0], m_med[0]);
      end
      checks++;
      if (m_leaf[9] !== {9'd300, 11'd5, 11'd4, 11'd3, 11'd2, 11'd1}) begin
         errors++;
         $display("FAIL %s leaf1_slot1: got %h, want %h", tag, m_leaf[9], {9'd300, 11'd5, 11'd4, 11'd3, 11'd2, 11'd1});
      end
      checks++;
      if (n_deq_empty !== 0) begin
         errors++;
         $display("FAIL %s deq_while_empty: got %0d, want 0", tag, n_deq_empty);
      end
   endtask

   task automatic check_final_pop(input string tag);
      stream(TW - 1, TW, -1);
      checks++;
      if (load_done !== 1'b0 || load_busy !== 1'b1) begin
         errors++;
         $display("FAIL %s before_last_pop: got done/busy=%b/%b, want 0/1", tag, load_done, load_busy);
      end
      stream(TW, TW, -1);
      checks++;
      if (load_done !== 1'b1 || load_busy !== 1'b0 || query_wen !== 1'b1) begin
         errors++;
         $display("FAIL %s after_last_pop: got done/busy/qwen=%b/%b/%b, want 1/0/1", tag, load_done, load_busy, query_wen);
      end
   endtask

   task automatic test_reset();
      int deq_cnt = 0;
      rst = 1'b1; load_kdtree = 1'b0; fifo_rempty_n = 1'b1; fifo_rdata = 11'h123;
      @(negedge clk); @(negedge clk);
      checks++;
      if ({node_wen, leaf_wen, query_wen, load_busy, load_done, fifo_deq} !== 6'b0) begin
         errors++;
         $display("FAIL reset_flags: got %b, want 000000", {node_wen, leaf_wen, query_wen, load_busy, load_done, fifo_deq});
      end
      checks++;
      if ({node_waddr, node_dim, node_median, leaf_waddr, leaf_slot, leaf_wdata, query_waddr, query_wdata} !== '0) begin
         errors++;
         $display("FAIL reset_data: got nonzero address/data outputs, want all 0");
      end
      @(posedge clk); #1;
      rst = 1'b0;
      clear_mon();
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         if (fifo_deq !== 1'b0) deq_cnt++;
         @(posedge clk); #1;
      end
      checks++;
      if (deq_cnt !== 0) begin errors++; $display("FAIL idle_no_pop: got %0d pops, want 0", deq_cnt); end
   endtask

   task automatic test_full_load();
      start_load();
      check_final_pop("full");
      @(negedge clk);
      @(posedge clk); #1;
      check_contents("full");
   endtask

   task automatic test_done_no_pop();
      int deq_cnt = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (fifo_deq !== 1'b0) deq_cnt++;
         @(posedge clk); #1;
      end
      checks++;
      if (deq_cnt !== 0 || load_done !== 1'b1 || n_query !== 494) begin
         errors++;
         $display("FAIL done_no_pop: got pops=%0d done=%b queries=%0d, want 0/1/494", deq_cnt, load_done, n_query);
      end
   endtask

   task automatic test_gapped_reload();
      clear_mon();
      start_load();
      stream(TW, NW + LW, NW + 100);
      checks++;
      if (load_done !== 1'b1 || query_wen !== 1'b1) begin
         errors++;
         $display("FAIL gapped_done: got done/qwen=%b/%b, want 1/1", load_done, query_wen);
      end
      @(negedge clk);
      @(posedge clk); #1;
      check_contents("gapped");
   endtask

   task automatic test_reset_mid_load();
      int deq_cnt = 0;
      int snap_n, snap_l, snap_q;
      clear_mon();
      start_load();
      stream(NW + 40, TW, -1);
      @(negedge clk);
      checks++;
      if (n_node !== 63 || n_leaf !== 6) begin
         errors++;
         $display("FAIL partial_counts: got %0d/%0d, want 63/6", n_node, n_leaf);
      end
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if ({leaf_wen, load_busy, load_done, fifo_deq, leaf_waddr, leaf_slot, leaf_wdata} !== '0) begin
         errors++;
         $display("FAIL midreset_outputs: got busy=%b deq=%b waddr=%0d, want all 0", load_busy, fifo_deq, leaf_waddr);
      end
      snap_n = n_node; snap_l = n_leaf; snap_q = n_query;
      @(posedge clk); #1;
      rst = 1'b0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (fifo_deq !== 1'b0) deq_cnt++;
         @(posedge clk); #1;
      end
      checks++;
      if (deq_cnt !== 0 || n_node !== snap_n || n_leaf !== snap_l || n_query !== snap_q) begin
         errors++;
         $display("FAIL midreset_quiet: got pops=%0d strobes=%0d/%0d/%0d, want 0 and %0d/%0d/%0d",
                  deq_cnt, n_node, n_leaf, n_query, snap_n, snap_l, snap_q);
      end
      clear_mon();
      start_load();
      check_final_pop("reload");
      @(negedge clk);
      @(posedge clk); #1;
      check_contents("reload");
   endtask

`ifdef KDTREE_LOADER_CHECK_EN
   task automatic test_load_err();
      clear_mon();
      bad_dim = 1'b1;
      start_load();
      stream(4, TW, -1);
      checks++;
      if (load_err !== 1'b1) begin errors++; $display("FAIL err_set: got %b, want 1", load_err); end
      stream(TW, TW, -1);
      @(negedge clk);
      checks++;
      if (load_err !== 1'b1 || m_dim[0] !== 3'd7) begin
         errors++;
         $display("FAIL err_sticky: got err=%b dim0=%0d, want 1/7", load_err, m_dim[0]);
      end
      @(posedge clk); #1;
      bad_dim = 1'b0;
      start_load();
      checks++;
      if (load_err !== 1'b0) begin errors++; $display("FAIL err_clear: got %b, want 0", load_err); end
      stream(TW, TW, -1);
   endtask
`endif

   initial begin
      test_reset();
      test_full_load();
      test_done_no_pop();
      test_gapped_reload();
      test_reset_mid_load();
`ifdef KDTREE_LOADER_CHECK_EN
      test_load_err();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/kdtree_stream_loader.md
Name: kdtree_stream_loader

Overview:
- Receive-side consumer of the input FIFO read port, inside `top`, in the `clk` domain.
- Deserialises the 11-bit host word stream into three memories, in this order: internal-node words, then leaf patch words, then query patch words.
- Issues write strobes to the node register file, leaf memory and query memory.
- Signals completion so the host may issue `fsm_start`.

Parameters:
- DATA_WIDTH, 11, width of one stream word.
- IDX_WIDTH, 9, width of the original-image patch index.
- PATCH_SIZE, 5, data words per patch.
- LEAF_SIZE, 8, patches per leaf.
- NUM_LEAVES, 64, leaves; internal nodes = NUM_LEAVES-1.
- NUM_QUERYS, 494, query patches (26*19).
- LEAF_ADDRW, $clog2(NUM_LEAVES), leaf/node address width.
- QUERY_ADDRW, $clog2(NUM_QUERYS), query address width.

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous active-high reset.
- load_kdtree  in  1  one-cycle start pulse.
- fifo_rempty_n  in  1  input FIFO holds data (first-word-fall-through).
- fifo_rdata  in  DATA_WIDTH  head word.
- fifo_deq  out  1  pop head word this cycle.
- node_wen  out  1  internal-node write strobe.
- node_waddr  out  LEAF_ADDRW  node number, 0..NUM_LEAVES-2.
- node_dim  out  3  split dimension.
- node_median  out  DATA_WIDTH  split value.
- leaf_wen  out  1  leaf patch write strobe.
- leaf_waddr  out  LEAF_ADDRW  leaf number.
- leaf_slot  out  $clog2(LEAF_SIZE)  patch slot in leaf.
- leaf_wdata  out  PATCH_SIZE*DATA_WIDTH+IDX_WIDTH  {idx, w4..w0}, with w0 in the LSBs.
- query_wen  out  1  query write strobe.
- query_waddr  out  QUERY_ADDRW  query number.
- query_wdata  out  PATCH_SIZE*DATA_WIDTH  {w4..w0}.
- load_busy  out  1  high from accept of load_kdtree until DONE.
- load_done  out  1  level, high in DONE.

Behaviour:
- Reset:
  - State IDLE; all counters 0.
  - All strobes, load_busy and load_done are 0.
  - All data/address outputs are 0.
- FSM states: IDLE, NODES, LEAVES, QUERIES, DONE.
- Transitions:
  - IDLE→NODES on load_kdtree.
  - NODES→LEAVES after word 2*(NUM_LEAVES-1) is popped.
  - LEAVES→QUERIES after word NUM_LEAVES*LEAF_SIZE*(PATCH_SIZE+1) is popped.
  - QUERIES→DONE after word NUM_QUERYS*PATCH_SIZE is popped.
  - DONE→NODES on load_kdtree (full reload; counters cleared).
- load_kdtree in NODES/LEAVES/QUERIES is ignored.
- Handshake:
  - fifo_deq = fifo_rempty_n & (state is NODES, LEAVES or QUERIES); combinational.
  - A word is consumed in the cycle fifo_deq=1 and is sampled from fifo_rdata in that cycle.
  - No pop occurs in IDLE or DONE; extra words remain in the FIFO.
  - Empty cycles stall the counters; no timeout.
- Node words (2 per node):
  - Word 0 is the dimension; its low 3 bits are kept.
  - Word 1 is the median; all bits are kept.
- Leaf words (6 per patch):
  - w0..w4 are data.
  - Word 5 is the patch index; its low IDX_WIDTH bits are kept.
  - Slot increments per patch; leaf increments after LEAF_SIZE patches.
- Query words: 5 per patch.
- Write timing:
  - Strobes are registered and pulse for exactly 1 cycle, the cycle after the last word of a record is popped.
  - Address and data are held stable until the next strobe.
  - Latency from last-word pop to strobe is 1 cycle.
  - Back-to-back records produce strobes spaced by the record length.
- State handoff: the final node strobe and the first leaf word pop may coincide (likewise leaf/query); both occur.
- Completion timing:
  - load_done rises the cycle after the final query pop, coincident with the last query_wen.
  - load_busy falls in that same cycle.
- Reset mid-load: everything returns to IDLE at once; partial records are discarded with no strobe.

Optional Feature:
- Macro: KDTREE_LOADER_CHECK_EN.
- Enabled:
  - Adds output `load_err` (1 bit, reset 0).
  - load_err is sticky and set on any of: a node dimension word ≥ PATCH_SIZE; a leaf index word ≥ NUM_QUERYS; a leaf-index word with bits above IDX_WIDTH nonzero.
  - Cleared only by rst or by the next accepted load_kdtree.
  - Data is still written unchanged.
- Disabled: the port and logic are absent.

Decomposition:
- Shared package kdtree_pkg holds:
  - the state enum typedef;
  - NUM_NODES, WORDS_PER_NODE=2, WORDS_PER_LEAF_PATCH=PATCH_SIZE+1 and the total word-count constants;
  - a packed leaf_patch_t struct {idx, data[PATCH_SIZE]}.
- One natural sub-module: word_gatherer, a shift-in register that takes N words and presents the assembled record plus a "record complete" flag. It is instantiated once with N=max record length and a runtime length select.

Test Plan:
- Reset, then load_kdtree with the FIFO streaming continuously (126 node + 3072 leaf + 2470 query words) → 63 node_wen, 512 leaf_wen, 494 query_wen. load_done rises the cycle after the 5668th pop.
- Node 0 words {2, 1023} → node_wen with node_waddr=0, node_dim=2, node_median=1023.
- Leaf stream where patch 9 is {1,2,3,4,5,300} → leaf_waddr=1, leaf_slot=1, idx=300, w0=1..w4=5.
- fifo_rempty_n toggled 1-in-3 during the query stream → identical memory contents to the continuous run; fifo_deq never asserted while empty.
- load_kdtree pulsed mid-LEAVES → ignored and counts unaffected. rst asserted after 40 leaf words → IDLE, no further strobes, reload from scratch succeeds.
- With KDTREE_LOADER_CHECK_EN: node dimension word 7 → load_err=1 and sticky. The next load_kdtree from DONE clears it.
